// File: rtl/dcache_dm_wb.sv
// dcache_dm_wb: direct-mapped, write-back, write-allocate data cache.
//
// The requester (MEM/WB stage) presents a load (rd_req) and/or a byte-lane
// store (wr_en/wr_data) at addr. A hit is serviced on the next clk edge.
// On a miss, miss is raised combinationally and the requester holds its
// inputs. The cache evicts the dirty victim line (if any), refills the line
// from memory, and then services the held request as an ordinary hit.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   rd_req        load request
//   wr_en[3:0]    store byte-lane enables (lane-aligned)
//   addr[31:0]    byte address (addr[1:0] ignored)
//   wr_data[31:0] store data (lane-aligned)
//   miss          request pending; requester must hold inputs while high
//   rd_data[31:0] registered load result, one cycle after the hit
//   mem_rd_req    line refill request (SWAP_IN only)
//   mem_wr_req    line writeback request (SWAP_OUT only)
//   mem_addr      line address {tag, set} of the current mem request
//   mem_wr_line   victim line being written back
//   mem_rd_line   refill line, sampled when mem_gnt is high in SWAP_IN
//   mem_gnt       single-cycle completion pulse for the current mem request
module dcache_dm_wb #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rd_req,
    input  logic [3:0]                         wr_en,
    input  logic [31:0]                        addr,
    input  logic [31:0]                        wr_data,
    output logic                               miss,
    output logic [31:0]                        rd_data,
    output logic                               mem_rd_req,
    output logic                               mem_wr_req,
    output logic [32-2-LINE_ADDR_LEN-1:0]      mem_addr,
    output logic [(32 << LINE_ADDR_LEN)-1:0]   mem_wr_line,
    input  logic [(32 << LINE_ADDR_LEN)-1:0]   mem_rd_line,
    input  logic                               mem_gnt
);
    localparam int TAG_ADDR_LEN = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int WORDS        = 1 << LINE_ADDR_LEN;
    localparam int SETS         = 1 << SET_ADDR_LEN;

    typedef logic [WORDS-1:0][31:0] line_t;
    typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;

    state_t                  state;
    line_t                   data_array [SETS];
    logic [TAG_ADDR_LEN-1:0] tag_array  [SETS];
    logic [SETS-1:0]         valid;
    logic [SETS-1:0]         dirty;
    logic [TAG_ADDR_LEN-1:0] miss_tag;
    logic [SET_ADDR_LEN-1:0] miss_set;
    line_t                   fill_line;

    logic [LINE_ADDR_LEN-1:0] word_idx;
    logic [SET_ADDR_LEN-1:0]  set_idx;
    logic [TAG_ADDR_LEN-1:0]  req_tag;
    logic                     req;
    logic                     hit;
    logic [31:0]              cur_word;
    logic [31:0]              merged_word;
    logic [1:0]               unused_byte_offset;

    assign word_idx = addr[LINE_ADDR_LEN+1:2];
    assign set_idx  = addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
    assign req_tag  = addr[31:LINE_ADDR_LEN+SET_ADDR_LEN+2];
    assign unused_byte_offset = addr[1:0];

    assign req  = rd_req | (|wr_en);
    // Hits are only recognised in IDLE, so a request is never serviced
    // while a refill or eviction is still in flight.
    assign hit  = (state == IDLE) && valid[set_idx] && (tag_array[set_idx] == req_tag);
    assign miss = req & ~hit;

    // Store merge: lanes with wr_en clear keep the current word's bytes.
    assign cur_word    = data_array[set_idx][word_idx];
    assign merged_word = {wr_en[3] ? wr_data[31:24] : cur_word[31:24],
                          wr_en[2] ? wr_data[23:16] : cur_word[23:16],
                          wr_en[1] ? wr_data[15:8]  : cur_word[15:8],
                          wr_en[0] ? wr_data[7:0]   : cur_word[7:0]};

    // Control and registered outputs: FSM, valid/dirty, load result and
    // the memory-side request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            valid       <= '0;
            dirty       <= '0;
            rd_data     <= '0;
            mem_rd_req  <= 1'b0;
            mem_wr_req  <= 1'b0;
            mem_addr    <= '0;
            mem_wr_line <= '0;
            miss_tag    <= '0;
            miss_set    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        // rd_data takes the pre-store word on a combined load/store.
                        if (rd_req) rd_data <= cur_word;
                        if (|wr_en) dirty[set_idx] <= 1'b1;
                    end else if (req) begin
                        miss_tag <= req_tag;
                        miss_set <= set_idx;
                        if (valid[set_idx] && dirty[set_idx]) begin
                            state       <= SWAP_OUT;
                            mem_wr_req  <= 1'b1;
                            mem_addr    <= {tag_array[set_idx], set_idx};
                            mem_wr_line <= data_array[set_idx];
                        end else begin
                            state      <= SWAP_IN;
                            mem_rd_req <= 1'b1;
                            mem_addr   <= {req_tag, set_idx};
                        end
                    end
                end
                SWAP_OUT: begin
                    if (mem_gnt) begin
                        state      <= SWAP_IN;
                        mem_wr_req <= 1'b0;
                        mem_rd_req <= 1'b1;
                        mem_addr   <= {miss_tag, miss_set};
                    end
                end
                SWAP_IN: begin
                    if (mem_gnt) begin
                        state      <= SWAP_IN_OK;
                        mem_rd_req <= 1'b0;
                    end
                end
                SWAP_IN_OK: begin
                    valid[miss_set] <= 1'b1;
                    dirty[miss_set] <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage arrays and the refill buffer carry no reset; valid bits
    // guard every read of them.
    always_ff @(posedge clk) begin
        if (hit && (|wr_en)) begin
            data_array[set_idx][word_idx] <= merged_word;
        end
        if ((state == SWAP_IN) && mem_gnt) begin
            fill_line <= mem_rd_line;
        end
        if (state == SWAP_IN_OK) begin
            data_array[miss_set] <= fill_line;
            tag_array[miss_set]  <= miss_tag;
        end
    end
endmodule
